wimpfi_rx_frame_filter: RTL and testbench

//  Parametrised frame filter/buffer between the Manchester byte receiver and the UART transmitter.

---
 rtl/wimpfi_rx_frame_filter.sv | 143 ++++++++++++++
 tb/tb_wimpfi_rx_frame_filter.sv | 261 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/wimpfi_rx_frame_filter.sv
// WimpFi receive frame filter: buffers each frame speculatively, commits or rewinds
// it at end of carrier, and streams committed bytes out on a valid/ready port.
module wimpfi_rx_frame_filter #(
    parameter int         DEPTH      = 256,
    parameter int         ERR_W      = 8,
    parameter logic [7:0] BCAST_ADDR = 8'h2A,
    parameter int         MIN_LEN    = 3
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [7:0]       mac_addr,
    input  logic             ignore_broadcast,
    input  logic             promisc,
    input  logic [7:0]       in_data,
    input  logic             in_valid,
    input  logic             cardet,
    input  logic             in_error,
    input  logic             crc_ok,
    output logic [7:0]       out_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             frame_good,
    output logic             frame_drop,
    output logic [ERR_W-1:0] rerrcnt,
    output logic [1:0]       state
);

    localparam int         AW       = $clog2(DEPTH);
    localparam int         PW       = AW + 1;
    localparam logic [7:0] CRC_TYPE = 8'h31;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RECV  = 2'd1,
        CHECK = 2'd2
    } state_t;

    // Handshake: a byte moves on every rising clk edge where out_valid and out_ready
    // are both high; out_data is held stable while out_valid is high and out_ready low.

    state_t          state_q, state_d;
    logic [7:0]      mem [DEPTH];
    logic [PW-1:0]   wr_spec, wr_commit, rd;
    logic [PW-1:0]   len;
    logic [7:0]      dest, ftype;
    logic            ovf, err;

    logic            full, empty, wr_en, rd_en;
    logic            addr_ok, accept, err_event, have_bytes;

    assign full       = ((wr_spec - rd) == PW'(DEPTH));
    assign empty      = (rd == wr_commit);
    assign wr_en      = (state_q == RECV) && in_valid && !full;
    assign out_valid  = !empty;
    assign rd_en      = out_valid && out_ready;
    assign out_data   = out_valid ? mem[rd[AW-1:0]] : 8'h00;
    assign state      = state_q;

    assign have_bytes = (len != '0);
    assign addr_ok    = promisc || (dest == mac_addr) ||
                        ((dest == BCAST_ADDR) && !ignore_broadcast);
    assign accept     = (len >= PW'(MIN_LEN)) && !ovf && !err && addr_ok &&
                        ((ftype != CRC_TYPE) || crc_ok);
    // A bad address alone is a silent drop; everything else that rejects counts.
    assign err_event  = have_bytes &&
                        (err || ovf || (len < PW'(MIN_LEN)) ||
                         (addr_ok && (ftype == CRC_TYPE) && !crc_ok));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= IDLE;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d    = state_q;
        frame_good = 1'b0;
        frame_drop = 1'b0;
        case (state_q)
            IDLE:  if (cardet) state_d = RECV;
            RECV:  if (!cardet) state_d = CHECK;
            CHECK: begin
                state_d = cardet ? RECV : IDLE;
                if (have_bytes) begin
                    frame_good = accept;
                    frame_drop = !accept;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (wr_en) mem[wr_spec[AW-1:0]] <= in_data;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_spec   <= '0;
            wr_commit <= '0;
            rd        <= '0;
            len       <= '0;
            dest      <= 8'h00;
            ftype     <= 8'h00;
            ovf       <= 1'b0;
            err       <= 1'b0;
            rerrcnt   <= '0;
        end else begin
            if (rd_en) rd <= rd + PW'(1);
            case (state_q)
                RECV: begin
                    if (in_valid) begin
                        if (len != PW'(DEPTH)) len <= len + PW'(1);
                        if (len == PW'(0)) dest <= in_data;
                        if (len == PW'(2)) ftype <= in_data;
                        if (full) ovf <= 1'b1;
                        else      wr_spec <= wr_spec + PW'(1);
                    end
                    if (in_error) err <= 1'b1;
                end
                CHECK: begin
                    if (have_bytes) begin
                        if (accept) wr_commit <= wr_spec;
                        else        wr_spec   <= wr_commit;
                    end
                    if (err_event && (rerrcnt != '1)) rerrcnt <= rerrcnt + ERR_W'(1);
                    len   <= '0;
                    dest  <= 8'h00;
                    ftype <= 8'h00;
                    ovf   <= 1'b0;
                    err   <= 1'b0;
                end
                default: begin
                    len   <= '0;
                    dest  <= 8'h00;
                    ftype <= 8'h00;
                    ovf   <= 1'b0;
                    err   <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_wimpfi_rx_frame_filter.sv
// Directed bench for wimpfi_rx_frame_filter: table of single-frame vectors plus
// hand-written overflow, back-to-back and mid-frame reset sequences.
module tb_wimpfi_rx_frame_filter;

    localparam int DEPTH = 16;
    localparam int ERR_W = 8;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic [7:0]       mac_addr = 8'h41;
    logic             ignore_broadcast = 1'b0;
    logic             promisc = 1'b0;
    logic [7:0]       in_data = 8'h00;
    logic             in_valid = 1'b0;
    logic             cardet = 1'b0;
    logic             in_error = 1'b0;
    logic             crc_ok = 1'b0;
    logic [7:0]       out_data;
    logic             out_valid;
    logic             out_ready = 1'b0;
    logic             frame_good;
    logic             frame_drop;
    logic [ERR_W-1:0] rerrcnt;
    logic [1:0]       state;

    wimpfi_rx_frame_filter #(.DEPTH(DEPTH), .ERR_W(ERR_W)) dut (
        .clk(clk), .rst_n(rst_n), .mac_addr(mac_addr),
        .ignore_broadcast(ignore_broadcast), .promisc(promisc),
        .in_data(in_data), .in_valid(in_valid), .cardet(cardet),
        .in_error(in_error), .crc_ok(crc_ok), .out_data(out_data),
        .out_valid(out_valid), .out_ready(out_ready), .frame_good(frame_good),
        .frame_drop(frame_drop), .rerrcnt(rerrcnt), .state(state)
    );

    // clock / reset
    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;
    int good_cnt = 0;
    int drop_cnt = 0;
    logic [7:0] exp_q[$];
    logic [7:0] fbuf [0:31];

    typedef struct {
        logic [0:7][7:0] data;
        int              n;
        bit              prom;
        bit              ign_bc;
        bit              crc;
        bit              rx_err;
        bit              exp_good;
        bit              exp_drop;
        int              exp_errcnt;
    } vec_t;

    vec_t vecs [16];
    int   nvec = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // scoreboard: every accepted output byte must match the head of exp_q
    always @(negedge clk) begin
        if (rst_n && out_valid && out_ready) begin
            checks++;
            if (exp_q.size() == 0) begin
                failures++;
                $display("FAIL out_unexpected: got %0h expected no byte", out_data);
            end else begin
                logic [7:0] e;
                e = exp_q.pop_front();
                if (out_data !== e) begin
                    failures++;
                    $display("FAIL out_data: got %0h expected %0h", out_data, e);
                end
            end
        end
    end

    always @(negedge clk) begin
        if (rst_n && frame_good) good_cnt++;
        if (rst_n && frame_drop) drop_cnt++;
    end

    // driver: bytes every other cycle; returns during the CHECK cycle
    task automatic send_frame(input int n, input bit rx_err);
        cardet = 1'b1;
        @(posedge clk); #1;
        for (int i = 0; i < n; i++) begin
            in_data  = fbuf[i];
            in_valid = 1'b1;
            in_error = rx_err && (i == 1);
            @(posedge clk); #1;
            in_valid = 1'b0;
            in_error = 1'b0;
            @(posedge clk); #1;
        end
        cardet = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic drain();
        int cyc;
        cyc = 0;
        out_ready = 1'b1;
        while ((exp_q.size() != 0 || out_valid) && cyc < 200) begin
            @(posedge clk); #1;
            cyc++;
        end
        if (cyc >= 200) check("drain_timeout", 32'd1, 32'd0);
        out_ready = 1'b0;
        check("drain_left", exp_q.size(), 0);
    endtask

    task automatic add_vec(input logic [63:0] d, input int n, input bit p, input bit ib,
                           input bit c, input bit e, input bit g, input bit dr, input int ec);
        vecs[nvec].data       = d;
        vecs[nvec].n          = n;
        vecs[nvec].prom       = p;
        vecs[nvec].ign_bc     = ib;
        vecs[nvec].crc        = c;
        vecs[nvec].rx_err     = e;
        vecs[nvec].exp_good   = g;
        vecs[nvec].exp_drop   = dr;
        vecs[nvec].exp_errcnt = ec;
        nvec++;
    endtask

    initial begin
        int g0, d0;
        // data, n, promisc, ignore_bc, crc_ok, in_error, good, drop, rerrcnt after
        add_vec(64'h41_42_30_48_69_00_00_00, 5, 0, 0, 0, 0, 1, 0, 0);
        add_vec(64'h43_42_30_00_00_00_00_00, 4, 0, 0, 0, 0, 0, 1, 0);
        add_vec(64'h43_42_30_00_00_00_00_00, 4, 1, 0, 0, 0, 1, 0, 0);
        add_vec(64'h2A_42_30_55_00_00_00_00, 4, 0, 1, 0, 0, 0, 1, 0);
        add_vec(64'h2A_42_30_55_00_00_00_00, 4, 0, 0, 0, 0, 1, 0, 0);
        add_vec(64'h41_42_31_10_20_00_00_00, 5, 0, 0, 0, 0, 0, 1, 1);
        add_vec(64'h41_42_31_10_20_00_00_00, 5, 0, 0, 1, 0, 1, 0, 1);
        add_vec(64'h41_42_00_00_00_00_00_00, 2, 0, 0, 0, 0, 0, 1, 2);
        add_vec(64'h41_42_30_77_00_00_00_00, 4, 0, 0, 0, 1, 0, 1, 3);
        add_vec(64'h43_42_31_99_00_00_00_00, 4, 0, 0, 0, 0, 0, 1, 3);
        add_vec(64'h00_00_00_00_00_00_00_00, 0, 0, 0, 0, 0, 0, 0, 3);
        add_vec(64'h2A_42_31_AA_00_00_00_00, 4, 0, 0, 0, 0, 0, 1, 4);

        repeat (3) @(posedge clk);
        #1;
        check("rst_out_valid", out_valid, 0);
        check("rst_state", state, 0);
        check("rst_rerrcnt", rerrcnt, 0);
        check("rst_pulses", {frame_good, frame_drop}, 0);
        rst_n = 1'b1;
        @(posedge clk); #1;

        for (int v = 0; v < nvec; v++) begin
            promisc          = vecs[v].prom;
            ignore_broadcast = vecs[v].ign_bc;
            crc_ok           = vecs[v].crc;
            for (int i = 0; i < 8; i++) fbuf[i] = vecs[v].data[i];
            g0 = good_cnt;
            d0 = drop_cnt;
            send_frame(vecs[v].n, vecs[v].rx_err);
            check($sformatf("v%0d_valid_in_check", v), out_valid, 0);
            @(posedge clk); #1;
            check($sformatf("v%0d_valid_after", v), out_valid, vecs[v].exp_good);
            if (vecs[v].exp_good) check($sformatf("v%0d_first_byte", v), out_data, vecs[v].data[0]);
            @(posedge clk); #1;
            check($sformatf("v%0d_good", v), good_cnt - g0, vecs[v].exp_good);
            check($sformatf("v%0d_drop", v), drop_cnt - d0, vecs[v].exp_drop);
            check($sformatf("v%0d_rerrcnt", v), rerrcnt, vecs[v].exp_errcnt);
            check($sformatf("v%0d_state", v), state, 0);
            if (vecs[v].exp_good)
                for (int i = 0; i < vecs[v].n; i++) exp_q.push_back(vecs[v].data[i]);
            drain();
        end
        promisc = 1'b0;
        ignore_broadcast = 1'b0;
        crc_ok = 1'b0;

        // overflow: 20 bytes into a 16-byte buffer with the sink stalled
        fbuf[0] = 8'h41; fbuf[1] = 8'h42; fbuf[2] = 8'h30;
        for (int i = 3; i < 20; i++) fbuf[i] = 8'(i);
        d0 = drop_cnt;
        send_frame(20, 1'b0);
        repeat (2) @(posedge clk);
        #1;
        check("ovf_drop", drop_cnt - d0, 1);
        check("ovf_rerrcnt", rerrcnt, 5);
        check("ovf_empty", out_valid, 0);
        fbuf[0] = 8'h41; fbuf[1] = 8'h42; fbuf[2] = 8'h30; fbuf[3] = 8'h01; fbuf[4] = 8'h02;
        g0 = good_cnt;
        send_frame(5, 1'b0);
        repeat (2) @(posedge clk);
        #1;
        check("post_ovf_good", good_cnt - g0, 1);
        for (int i = 0; i < 5; i++) exp_q.push_back(fbuf[i]);
        drain();

        // back-to-back frames, one-cycle CHECK gap, sink toggling
        exp_q.push_back(8'h41); exp_q.push_back(8'h42); exp_q.push_back(8'h30);
        exp_q.push_back(8'hA1); exp_q.push_back(8'hA2); exp_q.push_back(8'hA3);
        exp_q.push_back(8'h41); exp_q.push_back(8'h42); exp_q.push_back(8'h30);
        exp_q.push_back(8'hB1); exp_q.push_back(8'hB2);
        g0 = good_cnt;
        fork
            begin
                fbuf[0] = 8'h41; fbuf[1] = 8'h42; fbuf[2] = 8'h30;
                fbuf[3] = 8'hA1; fbuf[4] = 8'hA2; fbuf[5] = 8'hA3;
                send_frame(6, 1'b0);
                fbuf[3] = 8'hB1; fbuf[4] = 8'hB2;
                send_frame(5, 1'b0);
                repeat (2) @(posedge clk);
            end
            begin
                repeat (30) begin
                    @(posedge clk); #1;
                    out_ready = ~out_ready;
                end
            end
        join
        #1;
        check("b2b_good", good_cnt - g0, 2);
        drain();

        // reset pulsed mid-frame with committed data still buffered
        fbuf[0] = 8'h41; fbuf[1] = 8'h42; fbuf[2] = 8'h30; fbuf[3] = 8'h5A;
        send_frame(4, 1'b0);
        @(posedge clk); #1;
        check("pre_rst_valid", out_valid, 1);
        cardet = 1'b1;
        @(posedge clk); #1;
        in_data = 8'h41;
        in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        check("pre_rst_state", state, 1);
        rst_n = 1'b0;
        #1;
        check("mid_rst_valid", out_valid, 0);
        check("mid_rst_data", out_data, 0);
        check("mid_rst_pulses", {frame_good, frame_drop}, 0);
        check("mid_rst_rerrcnt", rerrcnt, 0);
        check("mid_rst_state", state, 0);
        cardet = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        check("post_rst_valid", out_valid, 0);
        check("post_rst_state", state, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
